// File: rtl/xswitch_src_tx.sv
// xswitch_src_tx: queues user commands and presents them one at a time to a
// switch source port using a wr_en / data_rcv handshake.
//
// Parameters
//   DEPTH   : command queue entries (power of 2, 2..16)
//   TIMEOUT : REQ cycles without data_rcv before the head is abandoned
// Optional feature (macro XSW_TX_TIMEOUT_EN): REQ timeout with timeout_err
//   pulse. Without the macro REQ waits indefinitely and timeout_err is 0.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/addr/data : user command in, accepted when cmd_ready=1
//   cmd_ready           : queue has room
//   addr_in, data_in    : head command presented to the switch (0 outside REQ)
//   wr_en               : write request to the switch
//   data_rcv            : switch acknowledge, honoured only in REQ
//   fifo_full           : switch FIFO full, blocks starting a new request
//   busy                : queue non-empty or FSM not idle
//   timeout_err         : one-cycle pulse when a write is abandoned
//   sent_cnt            : acknowledged writes (wraps)
module xswitch_src_tx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic [3:0]  addr_in,
  output logic [7:0]  data_in,
  output logic        wr_en,
  input  logic        data_rcv,
  input  logic        fifo_full,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] sent_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

`ifdef XSW_TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  cmd_t               mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [3:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        sent_cnt_q, sent_cnt_d;

  logic               push, pop, ack;
  cmd_t               cmd_in, head;

  assign cmd_in = {cmd_addr, cmd_data};
  assign push   = cmd_valid & cmd_ready_q;
  // An empty queue being written this cycle lets IDLE launch the new command
  // directly, giving accept-to-wr_en latency of one cycle.
  assign head   = (count_q != '0) ? mem_q[rd_ptr_q] : cmd_in;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    ack       = 1'b0;
    timeout_d = 1'b0;
    tmo_d     = tmo_q;
    addr_d    = '0;
    data_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (((count_q != '0) || push) && !fifo_full) begin
          state_d = REQ;
          addr_d  = head.addr;
          data_d  = head.data;
          tmo_d   = '0;
        end
      end
      REQ: begin
        addr_d = addr_q;
        data_d = data_q;
        // An acknowledge on the final allowed cycle wins over the timeout.
        if (data_rcv) begin
          pop     = 1'b1;
          ack     = 1'b1;
          state_d = GAP;
          addr_d  = '0;
          data_d  = '0;
        end else if (TMO_EN && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          pop       = 1'b1;
          timeout_d = 1'b1;
          state_d   = GAP;
          addr_d    = '0;
          data_d    = '0;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    sent_cnt_d  = ack ? (sent_cnt_q + 16'd1) : sent_cnt_q;
    wr_en_d     = (state_d == REQ);
    cmd_ready_d = (count_d != CNT_W'(DEPTH));
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      sent_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= cmd_ready_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

  // Queue storage; contents are don't-care while the occupancy is zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wr_en       = wr_en_q;
  assign addr_in     = addr_q;
  assign data_in     = data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign sent_cnt    = sent_cnt_q;

endmodule
